// File: rtl/data_write_buffer_if.sv
// Cache-side and memory-side signal bundle of the posted write buffer.
// slave is the buffer's view; master is the cache/memory environment's view.
interface data_write_buffer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              CACHE_READ;
  logic              CACHE_WRITE;
  logic [ADDR_W-1:0] CACHE_ADDRESS;
  logic [DATA_W-1:0] CACHE_WRITEDATA;
  logic [DATA_W-1:0] CACHE_READDATA;
  logic              CACHE_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport slave (
    input  CACHE_READ, CACHE_WRITE, CACHE_ADDRESS, CACHE_WRITEDATA,
    output CACHE_READDATA, CACHE_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport master (
    output CACHE_READ, CACHE_WRITE, CACHE_ADDRESS, CACHE_WRITEDATA,
    input  CACHE_READDATA, CACHE_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/data_write_buffer.sv
// Posted write buffer: absorbs cache write-backs into a small FIFO, drains them to memory
// in the background, serves read hits from the FIFO and forwards read misses ahead of drains.
module data_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input logic                CLK,
  input logic                RESET,
  data_write_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StDrain, StRd, StRdDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic            req_read, req_write, full, read_miss, head_locked;
  logic            hit, co_hit, push, pop, coalesce;
  logic [PtrW-1:0] hit_idx, co_idx;

  assign req_write = bus.CACHE_WRITE;
  assign req_read  = bus.CACHE_READ && !bus.CACHE_WRITE;
  assign full      = (count_q == CntW'(DEPTH));
  assign read_miss = req_read && !hit;
  // The head is frozen once its contents are (or are about to be) latched into the memory regs.
  assign head_locked = (state_q == StDrain) ||
                       (state_q == StIdle && !read_miss && count_q != '0);

  // Read hit: youngest valid match, head included.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) < count_q && addr_q[head_q + PtrW'(i)] == bus.CACHE_ADDRESS) begin
        hit     = 1'b1;
        hit_idx = head_q + PtrW'(i);
      end
    end
  end

  // Coalesce target: valid match excluding a locked head.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CntW'(i) < count_q && !(i == 0 && head_locked) &&
          addr_q[head_q + PtrW'(i)] == bus.CACHE_ADDRESS) begin
        co_hit = 1'b1;
        co_idx = head_q + PtrW'(i);
      end
    end
  end

  assign coalesce = req_write && co_hit;
  assign push     = req_write && !co_hit && !full;
  assign pop      = (state_q == StDrain) && !bus.MEM_BUSYWAIT;

  assign bus.CACHE_BUSYWAIT = (req_write && !co_hit && full) ||
                              (req_read && !hit && state_q != StRdDone);

  always_comb begin
    bus.CACHE_READDATA = '0;
    if (req_read && hit) begin
      bus.CACHE_READDATA = data_q[hit_idx];
    end else if (req_read && state_q == StRdDone) begin
      bus.CACHE_READDATA = rd_data_q;
    end
  end

  // Next-state logic; read misses win over draining.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (read_miss) begin
          state_d = StRd;
        end else if (count_q != '0) begin
          state_d = StDrain;
        end
      end
      StDrain:  if (!bus.MEM_BUSYWAIT) state_d = StIdle;
      StRd:     if (!bus.MEM_BUSYWAIT) state_d = StRdDone;
      StRdDone: state_d = StIdle;
    endcase
  end

  // Registered memory-port outputs.
  always_comb begin
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (state_d == StRd) begin
          mem_read_d = 1'b1;
          mem_addr_d = bus.CACHE_ADDRESS;
        end else if (state_d == StDrain) begin
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = data_q[head_q];
        end
      end
      StDrain:  if (state_d == StIdle) mem_write_d = 1'b0;
      StRd:     if (state_d == StRdDone) mem_read_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == StRd && !bus.MEM_BUSYWAIT) begin
        rd_data_q <= bus.MEM_READDATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Entry storage needs no reset: validity comes from head/count.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail_q] <= bus.CACHE_ADDRESS;
      data_q[tail_q] <= bus.CACHE_WRITEDATA;
    end else if (coalesce) begin
      data_q[co_idx] <= bus.CACHE_WRITEDATA;
    end
  end

  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
endmodule

// File: tb/tb_data_write_buffer.sv
// Directed bench for data_write_buffer with a fixed-latency memory model that logs drains.
module tb_data_write_buffer;
  localparam int unsigned MemLat = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  data_write_buffer_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  data_write_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  // Memory model: busy for MemLat cycles of each strobe, or while hold_busy is set.
  logic        hold_busy = 1'b0;
  logic [31:0] mem_rdata = 32'hDEADBEEF;
  int unsigned lat_cnt = 0;
  int unsigned wcount = 0, rcount = 0, rd_at_w = 0, strobe_cycles = 0;
  logic [5:0]  wlog_addr [64];
  logic [31:0] wlog_data [64];

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (hold_busy || lat_cnt < MemLat);
  assign bus.MEM_READDATA = mem_rdata;

  always @(posedge CLK) begin
    if (!(bus.MEM_READ || bus.MEM_WRITE)) lat_cnt <= 0;
    else if (lat_cnt < MemLat) lat_cnt <= lat_cnt + 1;
    if (bus.MEM_READ || bus.MEM_WRITE) strobe_cycles <= strobe_cycles + 1;
    if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT) begin
      wlog_addr[wcount[5:0]] <= bus.MEM_ADDRESS;
      wlog_data[wcount[5:0]] <= bus.MEM_WRITEDATA;
      wcount <= wcount + 1;
    end
    if (bus.MEM_READ && !bus.MEM_BUSYWAIT) begin
      rcount  <= rcount + 1;
      rd_at_w <= wcount;
    end
  end

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cache();
    bus.CACHE_READ  = 1'b0;
    bus.CACHE_WRITE = 1'b0;
  endtask

  task automatic drive_wr(input logic [5:0] a, input logic [31:0] d);
    bus.CACHE_READ      = 1'b0;
    bus.CACHE_WRITE     = 1'b1;
    bus.CACHE_ADDRESS   = a;
    bus.CACHE_WRITEDATA = d;
  endtask

  task automatic drive_rd(input logic [5:0] a);
    bus.CACHE_READ    = 1'b1;
    bus.CACHE_WRITE   = 1'b0;
    bus.CACHE_ADDRESS = a;
  endtask

  task automatic drain_all(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dut.count_q == '0 && !bus.MEM_WRITE && !bus.MEM_READ) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  int unsigned wbase, rbase, sbase;
  logic        accepted;
  logic [31:0] got;
  logic [5:0]  exp_a [5];
  logic [31:0] exp_d [5];

  initial begin
    bus.CACHE_READ = 1'b0; bus.CACHE_WRITE = 1'b0;
    bus.CACHE_ADDRESS = '0; bus.CACHE_WRITEDATA = '0;

    // Reset state
    #12;
    check_eq("rst_busywait", 32'(bus.CACHE_BUSYWAIT), 32'd0);
    check_eq("rst_readdata", bus.CACHE_READDATA, 32'd0);
    check_eq("rst_strobes", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.MEM_ADDRESS), 32'd0);
    check_eq("rst_mem_wdata", bus.MEM_WRITEDATA, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

    // Single write and background drain
    wbase = wcount;
    drive_wr(6'd5, 32'h11223344);
    @(negedge CLK);
    check_eq("t1_wr_busy", 32'(bus.CACHE_BUSYWAIT), 32'd0);
    tick();
    idle_cache();
    check_eq("t1_no_early_write", 32'(bus.MEM_WRITE), 32'd0);
    tick();
    check_eq("t1_mem_write", 32'(bus.MEM_WRITE), 32'd1);
    check_eq("t1_mem_addr", 32'(bus.MEM_ADDRESS), 32'd5);
    check_eq("t1_mem_wdata", bus.MEM_WRITEDATA, 32'h11223344);
    drain_all("t1_drain");
    check_eq("t1_wcount", wcount - wbase, 32'd1);
    check_eq("t1_log_addr", 32'(wlog_addr[wbase[5:0]]), 32'd5);
    check_eq("t1_log_data", wlog_data[wbase[5:0]], 32'h11223344);
    tick();
    check_eq("t1_gap_strobe", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);

    // Read hit on queued/draining entry
    wbase = wcount; rbase = rcount;
    drive_wr(6'd3, 32'hAAAA0001);
    tick();
    drive_rd(6'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_eq("t2_hit_busy", 32'(bus.CACHE_BUSYWAIT), 32'd0);
      check_eq("t2_hit_data", bus.CACHE_READDATA, 32'hAAAA0001);
      tick();
    end
    idle_cache();
    drain_all("t2_drain");
    check_eq("t2_no_mem_read", rcount - rbase, 32'd0);
    check_eq("t2_wcount", wcount - wbase, 32'd1);

    // Full buffer, coalesce while full, stall until first pop
    hold_busy = 1'b1;
    wbase = wcount;
    drive_wr(6'd1, 32'hB0000001); tick();
    drive_wr(6'd2, 32'hB0000002); tick();
    drive_wr(6'd3, 32'hB0000003); tick();
    drive_wr(6'd4, 32'hB0000004); tick();
    check_eq("t3_full_count", 32'(dut.count_q), 32'd4);
    drive_wr(6'd4, 32'hC0000004);
    @(negedge CLK);
    check_eq("t3_coalesce_busy", 32'(bus.CACHE_BUSYWAIT), 32'd0);
    tick();
    check_eq("t3_coalesce_count", 32'(dut.count_q), 32'd4);
    drive_wr(6'd9, 32'hB0000009);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_eq("t3_full_stall", 32'(bus.CACHE_BUSYWAIT), 32'd1);
      tick();
    end
    hold_busy = 1'b0;
    @(negedge CLK);
    check_eq("t3_stall_before_pop", 32'(bus.CACHE_BUSYWAIT), 32'd1);
    tick();
    @(negedge CLK);
    check_eq("t3_accept_after_pop", 32'(bus.CACHE_BUSYWAIT), 32'd0);
    tick();
    idle_cache();
    check_eq("t3_count_after_push", 32'(dut.count_q), 32'd4);
    drain_all("t3_drain");
    check_eq("t3_wcount", wcount - wbase, 32'd5);
    exp_a[0] = 6'd1; exp_d[0] = 32'hB0000001;
    exp_a[1] = 6'd2; exp_d[1] = 32'hB0000002;
    exp_a[2] = 6'd3; exp_d[2] = 32'hB0000003;
    exp_a[3] = 6'd4; exp_d[3] = 32'hC0000004;
    exp_a[4] = 6'd9; exp_d[4] = 32'hB0000009;
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_log_addr", 32'(wlog_addr[6'(wbase + k)]), 32'(exp_a[k]));
      check_eq("t3_log_data", wlog_data[6'(wbase + k)], exp_d[k]);
    end

    // Read miss forwarded between two drains
    wbase = wcount; rbase = rcount;
    drive_wr(6'd10, 32'h00000001); tick();
    drive_wr(6'd11, 32'h00000002); tick();
    drive_rd(6'h3F);
    accepted = 1'b0;
    got = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (!bus.CACHE_BUSYWAIT) begin
        accepted = 1'b1;
        got = bus.CACHE_READDATA;
        break;
      end
      tick();
    end
    check_eq("t4_miss_accepted", 32'(accepted), 32'd1);
    check_eq("t4_miss_data", got, 32'hDEADBEEF);
    check_eq("t4_read_after_one_drain", rd_at_w - wbase, 32'd1);
    check_eq("t4_one_mem_read", rcount - rbase, 32'd1);
    tick();
    idle_cache();
    drain_all("t4_drain");
    check_eq("t4_wcount", wcount - wbase, 32'd2);
    check_eq("t4_last_addr", 32'(wlog_addr[6'(wbase + 1)]), 32'd11);

    // Asynchronous reset mid-drain
    hold_busy = 1'b1;
    drive_wr(6'd20, 32'h20); tick();
    drive_wr(6'd21, 32'h21); tick();
    drive_wr(6'd22, 32'h22); tick();
    idle_cache();
    check_eq("t5_count", 32'(dut.count_q), 32'd3);
    check_eq("t5_draining", 32'(bus.MEM_WRITE), 32'd1);
    #3;
    RESET = 1'b0;
    #1;
    check_eq("t5_rst_mem_write", 32'(bus.MEM_WRITE), 32'd0);
    check_eq("t5_rst_mem_addr", 32'(bus.MEM_ADDRESS), 32'd0);
    check_eq("t5_rst_mem_wdata", bus.MEM_WRITEDATA, 32'd0);
    check_eq("t5_rst_count", 32'(dut.count_q), 32'd0);
    hold_busy = 1'b0;
    wbase = wcount; sbase = strobe_cycles;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (10) tick();
    check_eq("t5_no_traffic", strobe_cycles - sbase, 32'd0);
    check_eq("t5_no_writes", wcount - wbase, 32'd0);

    // Simultaneous read and write is a write
    wbase = wcount; rbase = rcount;
    bus.CACHE_READ = 1'b1; bus.CACHE_WRITE = 1'b1;
    bus.CACHE_ADDRESS = 6'd7; bus.CACHE_WRITEDATA = 32'h00000077;
    @(negedge CLK);
    check_eq("t6_busy", 32'(bus.CACHE_BUSYWAIT), 32'd0);
    check_eq("t6_readdata", bus.CACHE_READDATA, 32'd0);
    tick();
    idle_cache();
    check_eq("t6_count", 32'(dut.count_q), 32'd1);
    drain_all("t6_drain");
    check_eq("t6_wcount", wcount - wbase, 32'd1);
    check_eq("t6_log_addr", 32'(wlog_addr[wbase[5:0]]), 32'd7);
    check_eq("t6_log_data", wlog_data[wbase[5:0]], 32'h00000077);
    check_eq("t6_no_mem_read", rcount - rbase, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
